// File: rtl/framebuffer_scanout_if.sv
// Bus bundle for the raster scan-out engine: word-read port towards the
// framebuffer address mapper / BRAM and the 1-pixel valid/ready stream
// towards the video output stage.
interface framebuffer_scanout_if #(
   parameter int WORD_BITS = 16
);
   logic [9:0]           fb_x;
   logic [8:0]           fb_y;
   logic                 fb_rd;
   logic [WORD_BITS-1:0] fb_rdata;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 pix;
   logic                 pix_eol;
   logic                 pix_eof;

   // Scan-out engine side.
   modport master (
      output fb_x, fb_y, fb_rd, pix_valid, pix, pix_eol, pix_eof,
      input  fb_rdata, pix_ready
   );

   // Memory / pixel sink side.
   modport slave (
      input  fb_x, fb_y, fb_rd, pix_valid, pix, pix_eol, pix_eof,
      output fb_rdata, pix_ready
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// Raster scan-out engine. A credit-limited fetch walker reads 16-pixel words
// line by line, a small FIFO absorbs the one-cycle read latency, and a
// serialiser emits one pixel per beat (LSB first) with end-of-line/frame tags.
module framebuffer_scanout #(
   parameter int WIDTH      = 1024,
   parameter int HEIGHT     = 512,
   parameter int WORD_BITS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   framebuffer_scanout_if.master bus
);
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int IW = $clog2(WORD_BITS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [XW-1:0] X_LAST_WORD = XW'(WIDTH - WORD_BITS);
   localparam logic [XW-1:0] X_LAST_PIX  = XW'(WIDTH - 1);
   localparam logic [XW-1:0] X_STEP      = XW'(WORD_BITS);
   localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(WORD_BITS - 1);
   localparam logic [CW:0]   CREDITS     = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   fetch_state_e         state_q, state_d;
   logic [XW-1:0]        fb_x_q, fb_x_d;
   logic [YW-1:0]        fb_y_q, fb_y_d;
   logic                 fb_rd_q, fb_rd_d;
   logic                 inflight_q, inflight_d;
   logic [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [WORD_BITS-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WORD_BITS-1:0] ser_word_q, ser_word_d;
   logic [IW-1:0]        ser_idx_q, ser_idx_d;
   logic                 pix_valid_q, pix_valid_d;
   logic [XW-1:0]        pix_x_q, pix_x_d;
   logic [YW-1:0]        pix_y_q, pix_y_d;
   logic                 pix_q, pix_d;
   logic                 pix_eol_q, pix_eol_d;
   logic                 pix_eof_q, pix_eof_d;

   logic                 fifo_wr;
   logic                 ser_beat;
   logic                 ser_last;
   logic                 ser_load;
   logic [CW:0]          credit_used;

   // A restart discards whatever is arriving from the BRAM this cycle.
   assign fifo_wr  = inflight_q & ~frame_start;
   assign ser_beat = pix_valid_q & bus.pix_ready;
   assign ser_last = (ser_idx_q == IDX_LAST);
   // Load on empty or on the last beat of the word, so there is no bubble.
   assign ser_load = (cnt_q != {CW{1'b0}}) & (~pix_valid_q | (ser_beat & ser_last)) & ~frame_start;

   // Next-state logic for fetch walker, word FIFO and serialiser.
   always_comb begin
      state_d     = state_q;
      fb_x_d      = fb_x_q;
      fb_y_d      = fb_y_q;
      fb_rd_d     = 1'b0;
      inflight_d  = 1'b0;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      ser_word_d  = ser_word_q;
      ser_idx_d   = ser_idx_q;
      pix_valid_d = pix_valid_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      credit_used = {(CW+1){1'b0}};
      if (frame_start) begin
         // Fresh start or flush: everything restarts from pixel (0,0).
         state_d     = ST_FETCH;
         fb_x_d      = {XW{1'b0}};
         fb_y_d      = {YW{1'b0}};
         fb_rd_d     = 1'b1;
         wr_ptr_d    = {PW{1'b0}};
         rd_ptr_d    = {PW{1'b0}};
         cnt_d       = {CW{1'b0}};
         ser_word_d  = {WORD_BITS{1'b0}};
         ser_idx_d   = {IW{1'b0}};
         pix_valid_d = 1'b0;
         pix_x_d     = {XW{1'b0}};
         pix_y_d     = {YW{1'b0}};
      end else begin
         inflight_d = fb_rd_q;
         if (fifo_wr) begin
            mem_d[wr_ptr_q] = bus.fb_rdata;
            wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (ser_load) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + {{(CW-1){1'b0}}, fifo_wr} - {{(CW-1){1'b0}}, ser_load};
         // Advance the raster address after every issued read.
         if (fb_rd_q) begin
            if (fb_x_q == X_LAST_WORD) begin
               fb_x_d = {XW{1'b0}};
               if (fb_y_q == Y_LAST) begin
                  fb_y_d  = {YW{1'b0}};
                  state_d = ST_IDLE;
               end else begin
                  fb_y_d = fb_y_q + {{(YW-1){1'b0}}, 1'b1};
               end
            end else begin
               fb_x_d = fb_x_q + X_STEP;
            end
         end else begin
            fb_x_d = fb_x_q;
         end
         // Credits: words held after this edge plus the read now on the bus.
         credit_used = {1'b0, cnt_d} + {{CW{1'b0}}, fb_rd_q};
         fb_rd_d     = (state_d == ST_FETCH) && (credit_used < CREDITS);
         if (ser_load) begin
            ser_word_d  = mem_q[rd_ptr_q];
            ser_idx_d   = {IW{1'b0}};
            pix_valid_d = 1'b1;
         end else if (ser_beat) begin
            if (ser_last) begin
               pix_valid_d = 1'b0;
            end else begin
               ser_idx_d = ser_idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
         end else begin
            pix_valid_d = pix_valid_q;
         end
         if (ser_beat) begin
            if (pix_x_q == X_LAST_PIX) begin
               pix_x_d = {XW{1'b0}};
               if (pix_y_q == Y_LAST) begin
                  pix_y_d = {YW{1'b0}};
               end else begin
                  pix_y_d = pix_y_q + {{(YW-1){1'b0}}, 1'b1};
               end
            end else begin
               pix_x_d = pix_x_q + {{(XW-1){1'b0}}, 1'b1};
            end
         end else begin
            pix_x_d = pix_x_q;
         end
      end
      // Pixel outputs are registered versions of the next serialiser state.
      pix_d     = pix_valid_d ? ser_word_d[ser_idx_d] : 1'b0;
      pix_eol_d = pix_valid_d & (pix_x_d == X_LAST_PIX);
      pix_eof_d = pix_eol_d & (pix_y_d == Y_LAST);
   end

   // State registers, including the fetch FSM, with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fb_x_q      <= {XW{1'b0}};
         fb_y_q      <= {YW{1'b0}};
         fb_rd_q     <= 1'b0;
         inflight_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {WORD_BITS{1'b0}};
         end
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         cnt_q       <= {CW{1'b0}};
         ser_word_q  <= {WORD_BITS{1'b0}};
         ser_idx_q   <= {IW{1'b0}};
         pix_valid_q <= 1'b0;
         pix_x_q     <= {XW{1'b0}};
         pix_y_q     <= {YW{1'b0}};
         pix_q       <= 1'b0;
         pix_eol_q   <= 1'b0;
         pix_eof_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fb_x_q      <= fb_x_d;
         fb_y_q      <= fb_y_d;
         fb_rd_q     <= fb_rd_d;
         inflight_q  <= inflight_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ser_word_q  <= ser_word_d;
         ser_idx_q   <= ser_idx_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         pix_q       <= pix_d;
         pix_eol_q   <= pix_eol_d;
         pix_eof_q   <= pix_eof_d;
      end
   end

   assign bus.fb_x      = fb_x_q;
   assign bus.fb_y      = fb_y_q;
   assign bus.fb_rd     = fb_rd_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix       = pix_q;
   assign bus.pix_eol   = pix_eol_q;
   assign bus.pix_eof   = pix_eof_q;

   framebuffer_scanout_chk #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .fifo_wr  (fifo_wr),
      .fifo_cnt (cnt_q)
   );
endmodule

// Invariant checker: the credit scheme must never let a write hit a full FIFO.
module framebuffer_scanout_chk #(
   parameter int FIFO_DEPTH = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   input logic                         fifo_wr,
   input logic [$clog2(FIFO_DEPTH):0]  fifo_cnt
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_wr |-> (fifo_cnt < FULL_CNT));
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: each frame_start pushes the whole
// expected pixel stream; a negedge monitor pops and compares every beat.
module tb_framebuffer_scanout;
   localparam int W     = 1024;
   localparam int H     = 4;
   localparam int WB    = 16;
   localparam int DEPTH = 4;
   localparam int NPIX  = W * H;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;

   framebuffer_scanout_if #(.WORD_BITS(WB)) bus ();

   framebuffer_scanout #(
      .WIDTH(W), .HEIGHT(H), .WORD_BITS(WB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bus(bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q [$];
   int beat_cnt = 0, eol_cnt = 0, eof_cnt = 0, eof_beat = -1, rd_cnt = 0;
   logic prev_stall = 1'b0, prev_fs = 1'b0;
   logic [2:0] prev_out = 3'b000;
   logic [2:0] mon_got, mon_exp;
   logic bram_rd;
   logic [9:0] bram_x;
   logic [8:0] bram_y;

   function automatic logic [15:0] word_at(input logic [9:0] x, input logic [8:0] y);
      return {y[3:0], x[9:4], 6'b000000};
   endfunction

   // Reference: pixel n of the frame in raster order, as {pix, eol, eof}.
   function automatic logic [2:0] ref_beat(input int n);
      int x, y;
      logic [15:0] w;
      x = n % W;
      y = n / W;
      w = word_at(10'(x - (x % WB)), 9'(y));
      return {w[x % WB], (x == W - 1) ? 1'b1 : 1'b0, ((x == W - 1) && (y == H - 1)) ? 1'b1 : 1'b0};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // BRAM model: data for the address seen with fb_rd, one cycle later.
   always @(posedge clk) begin
      bram_rd = bus.fb_rd;
      bram_x  = bus.fb_x;
      bram_y  = bus.fb_y;
      #1;
      bus.fb_rdata = bram_rd ? word_at(bram_x, bram_y) : 16'($urandom);
   end

   // Read strobe counter.
   always @(negedge clk) begin
      if (rst_n && bus.fb_rd) rd_cnt++;
   end

   // Monitor: compares each transferring beat, and stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         mon_got = {bus.pix, bus.pix_eol, bus.pix_eof};
         if (prev_stall && !prev_fs)
            check("stall_hold", {bus.pix_valid, mon_got}, {1'b1, prev_out});
         if (bus.pix_valid && bus.pix_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", beat_cnt, -1);
            end else begin
               mon_exp = exp_q.pop_front();
               check($sformatf("pixel@beat%0d", beat_cnt), mon_got, mon_exp);
            end
            if (bus.pix_eol) eol_cnt++;
            if (bus.pix_eof) begin
               eof_cnt++;
               eof_beat = beat_cnt;
            end
            beat_cnt++;
         end
         prev_stall = bus.pix_valid && !bus.pix_ready;
         prev_out   = mon_got;
         prev_fs    = frame_start;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fb_x"}, bus.fb_x, 0);
      check({tag, "_fb_y"}, bus.fb_y, 0);
      check({tag, "_fb_rd"}, bus.fb_rd, 0);
      check({tag, "_pix_valid"}, bus.pix_valid, 0);
      check({tag, "_pix"}, bus.pix, 0);
      check({tag, "_pix_eol"}, bus.pix_eol, 0);
      check({tag, "_pix_eof"}, bus.pix_eof, 0);
   endtask

   // Called at posedge+1: pulse frame_start, load the scoreboard, check latency.
   task automatic start_frame();
      logic saved_ready;
      int lat;
      saved_ready   = bus.pix_ready;
      bus.pix_ready = 1'b0;
      frame_start   = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NPIX; i++) exp_q.push_back(ref_beat(i));
      beat_cnt = 0; eol_cnt = 0; eof_cnt = 0; eof_beat = -1; rd_cnt = 0;
      @(posedge clk); #1;
      frame_start   = 1'b0;
      bus.pix_ready = saved_ready;
      check("start_fb_rd", bus.fb_rd, 1);
      check("start_fb_x", bus.fb_x, 0);
      check("start_fb_y", bus.fb_y, 0);
      lat = 0;
      while (!bus.pix_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("first_valid_latency", lat, 3);
   endtask

   task automatic finish_frame(input string tag, input int budget, input bit rnd);
      int n, viol;
      n = 0;
      while (eof_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         if (rnd) bus.pix_ready = 1'($urandom);
         n++;
      end
      check({tag, "_eof_seen"}, eof_cnt != 0, 1);
      bus.pix_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check({tag, "_beats"}, beat_cnt, NPIX);
      check({tag, "_eol_count"}, eol_cnt, H);
      check({tag, "_eof_count"}, eof_cnt, 1);
      check({tag, "_eof_beat"}, eof_beat, NPIX - 1);
      check({tag, "_queue_left"}, exp_q.size(), 0);
      viol = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.pix_valid || bus.fb_rd) viol++;
      end
      check({tag, "_idle_after_eof"}, viol, 0);
   endtask

   initial begin
      int n, bubbles, viol;
      bus.pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      check("idle_before_start", {bus.fb_rd, bus.pix_valid}, 0);

      // Frame 1: pix_ready held high, no bubbles after the first beat.
      bus.pix_ready = 1'b1;
      start_frame();
      bubbles = 0;
      n = 0;
      while (!(bus.pix_valid && bus.pix_eof) && n < NPIX + 100) begin
         @(posedge clk); #1;
         n++;
         if (!bus.pix_valid) bubbles++;
      end
      check("no_bubbles", bubbles, 0);
      finish_frame("full_rate", 200, 1'b0);

      // Frame 2: random backpressure.
      start_frame();
      finish_frame("random_ready", 40000, 1'b1);

      // Frame 3: sink stalled; four words buffered plus one in the serialiser.
      bus.pix_ready = 1'b0;
      start_frame();
      repeat (100) begin @(posedge clk); #1; end
      check("stall_read_count", rd_cnt, DEPTH + 1);
      check("stall_fb_rd_low", bus.fb_rd, 0);
      check("stall_valid_held", bus.pix_valid, 1);
      bus.pix_ready = 1'b1;
      repeat (15) begin @(posedge clk); #1; end
      check("no_read_before_pop", bus.fb_rd, 0);
      @(posedge clk); #1;
      check("read_after_first_pop", bus.fb_rd, 1);
      finish_frame("stall_release", 10000, 1'b0);

      // Frame 4: flush mid-frame at/after pixel (517,2) with a read in flight.
      bus.pix_ready = 1'b1;
      start_frame();
      n = 0;
      while (beat_cnt < 2 * W + 517 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("reached_517_2", beat_cnt >= 2 * W + 517, 1);
      n = 0;
      while (!bus.fb_rd && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("read_in_flight_at_flush", bus.fb_rd, 1);
      start_frame();
      finish_frame("after_flush", 10000, 1'b0);

      // Asynchronous reset mid-line, then silence without frame_start.
      bus.pix_ready = 1'b1;
      start_frame();
      repeat (300) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      exp_q.delete();
      #10 rst_n = 1'b1;
      viol = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (bus.fb_rd || bus.pix_valid) viol++;
      end
      check("quiet_after_reset", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
